// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, register-file types and address helper
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam word_t REG_ZERO = '0;

    // Extra MSB keeps the compare meaningful when NUM_REGS == 2**REG_ADDR_W.
    function automatic logic addr_in_range(input reg_addr_t a);
        return {1'b0, a} < (REG_ADDR_W + 1)'(NUM_REGS);
    endfunction

endpackage

// File: rtl/mux2_1.sv
// rtl/mux2_1.sv - two-input word multiplexer, sel_i picks in2_i
module mux2_1 #(
    parameter int W = 32
) (
    input  logic [W-1:0] in1_i,
    input  logic [W-1:0] in2_i,
    input  logic         sel_i,
    output logic [W-1:0] out_o
);

    assign out_o = sel_i ? in2_i : in1_i;

endmodule

// File: rtl/register_file_wb.sv
// rtl/register_file_wb.sv - integer register file with write-back bypass
module register_file_wb
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            regWriteEnable,
    input  logic [REG_ADDR_W-1:0] writeAddress,
    input  logic [XLEN-1:0] dataBack,
    input  logic [REG_ADDR_W-1:0] readAddress1,
    input  logic [REG_ADDR_W-1:0] readAddress2,
    output logic [XLEN-1:0] readData1,
    output logic [XLEN-1:0] readData2,
    output logic [31:0]     writeCount
);

    word_t       regs_q [NUM_REGS];
    logic [31:0] write_count_q;
    logic [31:0] write_count_d;
    logic        wr_commit;
    logic        hit1;
    logic        hit2;
    word_t       arr1;
    word_t       arr2;
    word_t       byp1_out;
    word_t       byp2_out;

    assign wr_commit = regWriteEnable && (writeAddress != '0) && addr_in_range(writeAddress);

    always_comb begin
        write_count_d = write_count_q;
        if (wr_commit) begin
            write_count_d = write_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= REG_ZERO;
            end
            write_count_q <= '0;
        end else begin
            if (wr_commit) begin
                regs_q[writeAddress] <= dataBack;
            end
            write_count_q <= write_count_d;
        end
    end

    // Gated by reset so a write racing an asserting reset never leaks out.
    assign hit1 = wr_commit && !reset && (writeAddress == readAddress1);
    assign hit2 = wr_commit && !reset && (writeAddress == readAddress2);

    assign arr1 = regs_q[readAddress1];
    assign arr2 = regs_q[readAddress2];

    mux2_1 #(.W(XLEN)) byp1 (
        .in1_i (arr1),
        .in2_i (dataBack),
        .sel_i (hit1),
        .out_o (byp1_out)
    );

    mux2_1 #(.W(XLEN)) byp2 (
        .in1_i (arr2),
        .in2_i (dataBack),
        .sel_i (hit2),
        .out_o (byp2_out)
    );

    assign readData1 = (!reset && readAddress1 != '0 && addr_in_range(readAddress1)) ? byp1_out : REG_ZERO;
    assign readData2 = (!reset && readAddress2 != '0 && addr_in_range(readAddress2)) ? byp2_out : REG_ZERO;
    assign writeCount = write_count_q;

endmodule

// File: tb/tb_register_file_wb.sv
// tb/tb_register_file_wb.sv - scoreboard bench for register_file_wb
module tb_register_file_wb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        regWriteEnable = 1'b0;
    logic [4:0]  writeAddress = '0;
    logic [31:0] dataBack = '0;
    logic [4:0]  readAddress1 = '0;
    logic [4:0]  readAddress2 = '0;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] writeCount;

    typedef struct {
        logic [95:0] tag;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ec;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    register_file_wb dut (
        .clk            (clk),
        .reset          (reset),
        .regWriteEnable (regWriteEnable),
        .writeAddress   (writeAddress),
        .dataBack       (dataBack),
        .readAddress1   (readAddress1),
        .readAddress2   (readAddress2),
        .readData1      (readData1),
        .readData2      (readData2),
        .writeCount     (writeCount)
    );

    task automatic cmp(input logic [95:0] tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %0s.%0s actual=%08h required=%08h", tag, what, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            cmp(e.tag, "rd1", readData1, e.e1);
            cmp(e.tag, "rd2", readData2, e.e2);
            cmp(e.tag, "cnt", writeCount, e.ec);
        end
    end

    task automatic push(input logic [95:0] tag, input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] ec);
        exp_t e;
        e.tag = tag; e.e1 = e1; e.e2 = e2; e.ec = ec;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] d,
                         input logic [4:0] ra1, input logic [4:0] ra2, input logic rst);
        regWriteEnable = we;
        writeAddress   = wa;
        dataBack       = d;
        readAddress1   = ra1;
        readAddress2   = ra2;
        reset          = rst;
    endtask

    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] d,
                        input logic [4:0] ra1, input logic [4:0] ra2, input logic rst,
                        input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] ec,
                        input logic [95:0] tag);
        @(posedge clk); #1;
        drive(we, wa, d, ra1, ra2, rst);
        push(tag, e1, e2, ec);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        step(0, 0, 0,             1, 2, 0, 0, 0, 0, "rst_state");
        step(1, 5, 32'hDEADBEEF,  0, 0, 0, 0, 0, 0, "wr_x5");
        step(0, 0, 0,             5, 0, 0, 32'hDEADBEEF, 0, 1, "rd_x5");
        step(1, 0, 32'h12345678,  0, 5, 0, 0, 32'hDEADBEEF, 1, "wr_x0");
        step(0, 0, 0,             0, 5, 0, 0, 32'hDEADBEEF, 1, "rd_x0");
        step(1, 7, 32'hCAFEF00D,  7, 7, 0, 32'hCAFEF00D, 32'hCAFEF00D, 1, "byp_x7");
        step(0, 0, 0,             7, 7, 0, 32'hCAFEF00D, 32'hCAFEF00D, 2, "rd_x7");
        step(1, 8, 32'h11111111,  8, 7, 0, 32'h11111111, 32'hCAFEF00D, 2, "byp_x8");
        step(0, 9, 32'h77777777,  9, 8, 0, 0, 32'h11111111, 3, "we0_x9");
        step(0, 0, 0,             9, 5, 0, 0, 32'hDEADBEEF, 3, "rd_x9");
        step(1, 5, 32'h0BADF00D,  5, 1, 0, 32'h0BADF00D, 0, 3, "ovr_x5");
        step(0, 0, 0,             5, 7, 0, 32'h0BADF00D, 32'hCAFEF00D, 4, "rd_x5b");

        // Counter wrap: preload all-ones, then one more committed write.
        @(posedge clk); #1;
        force dut.write_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.write_count_q;
        drive(1, 3, 32'h13572468, 3, 5, 0);
        push("wrap_pre", 32'h13572468, 32'h0BADF00D, 32'hFFFF_FFFF);
        step(0, 0, 0,             3, 0, 0, 32'h13572468, 0, 0, "wrap");
        step(1, 4, 32'h24682468,  3, 4, 0, 32'h13572468, 32'h24682468, 0, "post_wrap");
        step(0, 0, 0,             4, 3, 0, 32'h24682468, 32'h13572468, 1, "cnt1");

        // Reset asserted between edges must clear outputs before the next edge.
        @(posedge clk); #1;
        drive(0, 0, 0, 5, 4, 0);
        push("rst_async", 0, 0, 0);
        #2 reset = 1'b1;
        for (int i = 1; i < 32; i++) begin
            step(1, 5'(i), 32'hFFFF0000 | 32'(i), 5'(i), 5'(32 - i), 1, 0, 0, 0, "rst_sweep");
        end
        step(0, 0, 0,             4, 5, 0, 0, 0, 0, "rst_rel");

        // Write coinciding with reset is lost.
        step(1, 9, 32'hA5A5A5A5,  9, 0, 1, 0, 0, 0, "rst_wr");
        step(0, 0, 0,             9, 9, 0, 0, 0, 0, "x9_after");
        step(1, 9, 32'hA5A5A5A5,  0, 0, 0, 0, 0, 0, "x9_wr");
        step(0, 0, 0,             9, 0, 0, 32'hA5A5A5A5, 0, 1, "x9_rd");

        for (int k = 0; k < 4 && sb_q.size() > 0; k++) @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
